// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the datapath (port 0) and the address/PC
// unit (port 1), holding each registered result until its owner consumes it.
module alu_share_arbiter #(
    parameter int W         = 8,
    parameter int FIXED_PRI = 0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [5:0]     req_op,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_n,
    output logic           rsp_z,
    output logic           rsp_err,
    output logic [W-1:0]   alu_in1,
    output logic [W-1:0]   alu_in2,
    output logic [2:0]     alu_op,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_n,
    input  logic           alu_z
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    logic       last_grant;
    logic       consume;
    logic       slot_free;
    logic [1:0] grant;
    logic       sel;
    logic       op_err;

    // The owner bit of rsp_valid masks rsp_ready, so the non-owner's ready is ignored.
    assign consume   = (state == HOLD) && ((rsp_valid & rsp_ready) != 2'b00);
    assign slot_free = !reset && ((state == IDLE) || consume);

    // When both ports ask, round-robin hands the slot to the port that did not win last.
    always_comb begin
        grant = 2'b00;
        if (slot_free) begin
            if (req_valid == 2'b11) begin
                grant = ((FIXED_PRI != 0) || last_grant) ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign req_ready = grant;
    assign sel       = grant[1];

    // Port 0 fields are driven whenever nothing is granted; the ALU output is then unused.
    assign alu_in1 = sel ? req_a[2*W-1:W] : req_a[W-1:0];
    assign alu_in2 = sel ? req_b[2*W-1:W] : req_b[W-1:0];
    assign alu_op  = sel ? req_op[5:3]    : req_op[2:0];
    assign op_err  = (alu_op > 3'd5);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
            rsp_n      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_err    <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant != 2'b00) begin
            state      <= HOLD;
            rsp_valid  <= grant;
            last_grant <= sel;
            rsp_err    <= op_err;
            if (op_err) begin
                rsp_data <= '0;
                rsp_n    <= 1'b0;
                rsp_z    <= 1'b1;
            end else begin
                rsp_data <= alu_out;
                rsp_n    <= alu_n;
                rsp_z    <= alu_z;
            end
        end else if (consume) begin
            state     <= IDLE;
            rsp_valid <= 2'b00;
        end
    end

endmodule
